// File: rtl/prog_mem_pkg.sv
// prog_mem_pkg: shared FSM state type, parity helper and stored-word width for prog_mem_loader
// Optional feature macro: PROG_MEM_PARITY_EN adds one even-parity bit to every stored word.
package prog_mem_pkg;
  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_e;
  // Parity operand is zero-extended to this width, which leaves the XOR-reduce unchanged.
  localparam int PARITY_MAX_W = 1024;
`ifdef PROG_MEM_PARITY_EN
  localparam int PARITY_W = 1;
`else
  localparam int PARITY_W = 0;
`endif
  function automatic int stored_width(input int data_size);
    return data_size + PARITY_W;
  endfunction
  function automatic logic parity(input logic [PARITY_MAX_W-1:0] w);
    return ^w;
  endfunction
endpackage

// File: rtl/prog_mem_loader_if.sv
// prog_mem_loader_if: loader stream and fetch port bundle
// master: host/boot controller and core fetch side; slave: prog_mem_loader.
// Loader: load_start/load_base/load_len, ld_valid/ld_data/ld_ready, load_busy, load_done.
// Fetch: fetch_en/fetch_addr in, fetch_data/fetch_valid/parity_err out.
interface prog_mem_loader_if #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 4
);
  logic                 load_start;
  logic [ADDR_SIZE-1:0] load_base;
  logic [ADDR_SIZE:0]   load_len;
  logic                 ld_valid;
  logic [DATA_SIZE-1:0] ld_data;
  logic                 ld_ready;
  logic                 load_busy;
  logic                 load_done;
  logic                 fetch_en;
  logic [ADDR_SIZE-1:0] fetch_addr;
  logic [DATA_SIZE-1:0] fetch_data;
  logic                 fetch_valid;
  logic                 parity_err;
  modport master (
    output load_start, load_base, load_len, ld_valid, ld_data, fetch_en, fetch_addr,
    input  ld_ready, load_busy, load_done, fetch_data, fetch_valid, parity_err
  );
  modport slave (
    input  load_start, load_base, load_len, ld_valid, ld_data, fetch_en, fetch_addr,
    output ld_ready, load_busy, load_done, fetch_data, fetch_valid, parity_err
  );
endinterface

// File: rtl/prog_mem_array.sv
// prog_mem_array: 2**ADDR_SIZE x WIDTH storage, one synchronous write port, one registered read port
// Ports: clk, rstn (sync active-low, clears rdata only), we/waddr/wdata write, re/raddr read, rdata.
// Contents are never cleared; rdata holds when re is low.
module prog_mem_array #(
  parameter int WIDTH     = 16,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);
  logic [WIDTH-1:0] mem [2**ADDR_SIZE];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk)
    if (!rstn) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/prog_mem_loader.sv
// prog_mem_loader: program memory with auto-incrementing streaming loader and 1-cycle fetch port
// Ports: clk, rstn (sync active-low), bus (prog_mem_loader_if.slave: loader stream + fetch port).
// Macro PROG_MEM_PARITY_EN: store an even-parity bit per word and flag mismatches on fetch;
// when undefined parity_err is tied low.
module prog_mem_loader
  import prog_mem_pkg::*;
#(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 4
) (
  input logic clk,
  input logic rstn,
  prog_mem_loader_if.slave bus
);
  localparam int SW = stored_width(DATA_SIZE);
  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_LOAD = LOAD;
  logic [0:0]           state;
  logic [ADDR_SIZE-1:0] ptr;
  logic [ADDR_SIZE:0]   cnt;
  logic                 load_done;
  logic                 fetch_valid;
  logic                 beat;
  logic                 fetch_go;
  logic [SW-1:0]        wword;
  logic [SW-1:0]        rword;
  assign beat     = state == ST_LOAD && bus.ld_valid;
  assign fetch_go = state == ST_IDLE && bus.fetch_en;
`ifdef PROG_MEM_PARITY_EN
  assign wword          = {parity(PARITY_MAX_W'(bus.ld_data)), bus.ld_data};
  // Stored word has even parity, so any nonzero XOR over the whole read word is an error.
  assign bus.parity_err = fetch_valid && ^rword;
`else
  assign wword          = bus.ld_data;
  assign bus.parity_err = 1'b0;
`endif
  assign bus.fetch_data  = rword[DATA_SIZE-1:0];
  assign bus.fetch_valid = fetch_valid;
  assign bus.ld_ready    = state == ST_LOAD;
  assign bus.load_busy   = state == ST_LOAD;
  assign bus.load_done   = load_done;
  // Writes are gated by rstn so a reset landing on a beat cannot commit it.
  prog_mem_array #(.WIDTH(SW), .ADDR_SIZE(ADDR_SIZE)) u_arr (
    .clk   (clk),
    .rstn  (rstn),
    .we    (beat && rstn),
    .waddr (ptr),
    .wdata (wword),
    .re    (fetch_go),
    .raddr (bus.fetch_addr),
    .rdata (rword)
  );
  always_ff @(posedge clk)
    if (!rstn) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      cnt         <= '0;
      load_done   <= 1'b0;
      fetch_valid <= 1'b0;
    end else begin
      load_done   <= 1'b0;
      fetch_valid <= fetch_go;
      if (state == ST_IDLE && bus.load_start) begin
        load_done <= bus.load_len == '0;
        state     <= bus.load_len == '0 ? ST_IDLE : ST_LOAD;
        ptr       <= bus.load_base;
        cnt       <= bus.load_len;
      end else if (beat) begin
        ptr <= ptr + 1'b1;
        cnt <= cnt - 1'b1;
        if (cnt == (ADDR_SIZE+1)'(1)) begin
          state     <= ST_IDLE;
          load_done <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: self-checking bench for prog_mem_loader (cycle model + fetch scoreboard + vector table)
module tb_prog_mem_loader;
  typedef struct {
    logic [15:0] d;
    logic        pe;
  } sb_t;
  typedef struct {
    logic [3:0]  addr;
    logic [15:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int failures = 0;
  prog_mem_loader_if #(.DATA_SIZE(16), .ADDR_SIZE(4)) bus ();
  prog_mem_loader #(.DATA_SIZE(16), .ADDR_SIZE(4)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  logic        m_busy = 1'b0, m_done = 1'b0, m_fv = 1'b0, m_pe = 1'b0;
  logic [15:0] m_fd = '0;
  logic [3:0]  m_ptr = '0;
  int          m_cnt = 0;
  int          bad_addr = -1;
  logic [15:0] mem_m [16];
  logic [15:0] words [8];
  sb_t         sb [$];
  vec_t        vec [9];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", n, act, exp, $time);
    end
  endtask
  task automatic step();
    sb_t e;
    @(posedge clk);
    if (!rstn) begin
      m_busy = 0; m_done = 0; m_fv = 0; m_fd = '0;
      sb.delete();
    end else begin
      m_fv = !m_busy && bus.fetch_en;
      if (m_fv) sb.push_back('{d: mem_m[bus.fetch_addr], pe: int'(bus.fetch_addr) == bad_addr});
      m_done = 0;
      if (!m_busy && bus.load_start) begin
        if (bus.load_len == 0) m_done = 1;
        else begin
          m_busy = 1; m_ptr = bus.load_base; m_cnt = int'(bus.load_len);
        end
      end else if (m_busy && bus.ld_valid) begin
        mem_m[m_ptr] = bus.ld_data;
        m_ptr = m_ptr + 4'd1;
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0; m_done = 1;
        end
      end
    end
    #1;
    m_pe = 1'b0;
    if (m_fv) begin
      e = sb.pop_front();
      m_fd = e.d;
      m_pe = e.pe;
    end
    chk("ld_ready", 32'(bus.ld_ready), 32'(m_busy));
    chk("load_busy", 32'(bus.load_busy), 32'(m_busy));
    chk("load_done", 32'(bus.load_done), 32'(m_done));
    chk("fetch_valid", 32'(bus.fetch_valid), 32'(m_fv));
    chk("fetch_data", 32'(bus.fetch_data), 32'(m_fd));
    chk("parity_err", 32'(bus.parity_err), 32'(m_pe));
  endtask
  task automatic do_load(input logic [3:0] base, input int len);
    int steps = 0;
    int done_at = -1;
    bus.load_start = 1'b1; bus.load_base = base; bus.load_len = 5'(len);
    step(); steps++;
    bus.load_start = 1'b0;
    for (int i = 0; i < len; i++) begin
      bus.ld_valid = 1'b1; bus.ld_data = words[i];
      step(); steps++;
      if (bus.load_done && done_at < 0) done_at = steps;
    end
    bus.ld_valid = 1'b0;
    step();
    chk("done_cycle", 32'(done_at), 32'(len + 1));
  endtask
  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      bus.fetch_en = 1'b1; bus.fetch_addr = vec[i].addr;
      step();
      chk("vec_valid", 32'(bus.fetch_valid), 32'd1);
      chk("vec_data", 32'(bus.fetch_data), 32'(vec[i].exp));
    end
    bus.fetch_en = 1'b0;
    step();
  endtask
  initial begin
    vec[0] = '{4'd0, 16'h1111}; vec[1] = '{4'd1, 16'h2222};
    vec[2] = '{4'd2, 16'h3333}; vec[3] = '{4'd3, 16'h4444};
    vec[4] = '{4'd14, 16'hAAAA}; vec[5] = '{4'd15, 16'hBBBB};
    vec[6] = '{4'd0, 16'hCCCC}; vec[7] = '{4'd1, 16'hDDDD};
    vec[8] = '{4'd2, 16'h3333};
    bus.load_start = 0; bus.load_base = '0; bus.load_len = '0;
    bus.ld_valid = 0; bus.ld_data = '0; bus.fetch_en = 0; bus.fetch_addr = '0;
    step(); step();
    chk("rst_ready", 32'(bus.ld_ready), 32'd0);
    chk("rst_fetch_data", 32'(bus.fetch_data), 32'd0);
    rstn = 1'b1;
    step();
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
    do_load(4'd0, 4);
    run_vecs(0, 4);
    words[0] = 16'hAAAA; words[1] = 16'hBBBB; words[2] = 16'hCCCC; words[3] = 16'hDDDD;
    do_load(4'd14, 4);
    run_vecs(4, 9);
    // stalled stream: ld_valid 1,0,0,1 for len=2
    bus.load_start = 1; bus.load_base = 4'd5; bus.load_len = 5'd2;
    step();
    bus.load_start = 0;
    bus.ld_valid = 1; bus.ld_data = 16'h5555; step();
    bus.ld_valid = 0; bus.ld_data = 16'hBAD0; step(); step();
    chk("stall_busy", 32'(bus.load_busy), 32'd1);
    bus.ld_valid = 1; bus.ld_data = 16'h6666; step();
    chk("stall_done", 32'(bus.load_done), 32'd1);
    bus.ld_valid = 0; step();
    chk("stall_done_drop", 32'(bus.load_done), 32'd0);
    bus.fetch_en = 1; bus.fetch_addr = 4'd5; step();
    chk("stall_w0", 32'(bus.fetch_data), 32'h5555);
    bus.fetch_addr = 4'd6; step();
    chk("stall_w1", 32'(bus.fetch_data), 32'h6666);
    bus.fetch_en = 0; step();
    // fetch during LOAD is dropped
    bus.load_start = 1; bus.load_base = 4'd8; bus.load_len = 5'd2;
    step();
    bus.load_start = 0; bus.fetch_en = 1; bus.fetch_addr = 4'd0;
    bus.ld_valid = 1; bus.ld_data = 16'h8888; step();
    chk("drop_valid", 32'(bus.fetch_valid), 32'd0);
    chk("drop_hold", 32'(bus.fetch_data), 32'h6666);
    bus.ld_data = 16'h9999; step();
    bus.ld_valid = 0; bus.fetch_en = 0; step();
    // simultaneous fetch_en + load_start: old word returned, burst starts
    bus.fetch_en = 1; bus.fetch_addr = 4'd8;
    bus.load_start = 1; bus.load_base = 4'd8; bus.load_len = 5'd1;
    step();
    chk("sim_old", 32'(bus.fetch_data), 32'h8888);
    chk("sim_busy", 32'(bus.load_busy), 32'd1);
    bus.fetch_en = 0; bus.load_start = 0;
    bus.ld_valid = 1; bus.ld_data = 16'h7777; step();
    chk("sim_done", 32'(bus.load_done), 32'd1);
    bus.ld_valid = 0;
    bus.fetch_en = 1; bus.fetch_addr = 4'd8; step();
    chk("sim_new", 32'(bus.fetch_data), 32'h7777);
    bus.fetch_en = 0; step();
    // zero-length load
    bus.load_start = 1; bus.load_base = 4'd2; bus.load_len = 5'd0;
    bus.ld_valid = 1; bus.ld_data = 16'hDEAD;
    step();
    chk("len0_done", 32'(bus.load_done), 32'd1);
    chk("len0_busy", 32'(bus.load_busy), 32'd0);
    bus.load_start = 0; bus.ld_valid = 0;
    step();
    chk("len0_done_drop", 32'(bus.load_done), 32'd0);
    bus.fetch_en = 1; bus.fetch_addr = 4'd2; step();
    chk("len0_nowrite", 32'(bus.fetch_data), 32'h3333);
    bus.fetch_en = 0; step();
    // reset mid-burst after 2 of 4 words
    bus.load_start = 1; bus.load_base = 4'd0; bus.load_len = 5'd4;
    step();
    bus.load_start = 0;
    bus.ld_valid = 1; bus.ld_data = 16'hE001; step();
    bus.ld_data = 16'hE002; step();
    bus.ld_data = 16'hE003; rstn = 1'b0; step();
    chk("abort_busy", 32'(bus.load_busy), 32'd0);
    rstn = 1'b1; bus.ld_valid = 0; step();
    chk("abort_no_done", 32'(bus.load_done), 32'd0);
    for (int a = 0; a < 4; a++) begin
      bus.fetch_en = 1; bus.fetch_addr = 4'(a); step();
    end
    chk("abort_w3_kept", 32'(bus.fetch_data), 32'h4444);
    bus.fetch_en = 0; step();
`ifdef PROG_MEM_PARITY_EN
    dut.u_arr.mem[3][0] = ~dut.u_arr.mem[3][0];
    mem_m[3] = mem_m[3] ^ 16'h0001;
    bad_addr = 3;
    bus.fetch_en = 1; bus.fetch_addr = 4'd3; step();
    chk("par_err", 32'(bus.parity_err), 32'd1);
    bus.fetch_addr = 4'd2; step();
    chk("par_ok", 32'(bus.parity_err), 32'd0);
    bus.fetch_en = 0; step();
`endif
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
